// File: rtl/ula_seq.sv
// ula_seq: registered ALU with single-cycle logic/arith ops, iterative signed MUL and SRA,
// zero/negative/overflow flags and a start/busy/done handshake.
module ula_seq #(
  parameter int NUM_BITS = 8,
  parameter int SH_BITS = $clog2(NUM_BITS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          F,
  input  logic [NUM_BITS-1:0] A,
  input  logic [NUM_BITS-1:0] B,
  output logic [NUM_BITS-1:0] Saida,
  output logic                FLAG_O,
  output logic                FLAG_Z,
  output logic                FLAG_N,
  output logic                busy,
  output logic                done
);
  localparam int W = NUM_BITS;
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state, state_n;
  logic [2*W-1:0] acc, mc, pp, acc_n;
  logic [W-1:0] mp, sh, sh_n, sum, dif, r1, res;
  logic [SH_BITS-1:0] cnt, k;
  logic is_mul, accept, multi, last, complete, slt, o1, ovf;
  assign k = B[SH_BITS-1:0];
  assign accept = start && state == IDLE;
  assign multi = F == 3'b110 || (F == 3'b111 && k != '0);
  assign last = state == EXEC && (is_mul ? cnt == SH_BITS'(W-1) : cnt == SH_BITS'(1));
  assign complete = (accept && !multi) || last;
  assign busy = state == EXEC;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (accept && multi ? EXEC : IDLE) : (last ? IDLE : EXEC);
    sum = A + B;
    dif = A - B;
    slt = $signed(A) < $signed(B);
    // the multiplier MSB carries negative weight, so its partial product is subtracted
    pp = mp[0] ? mc : '0;
    acc_n = cnt == SH_BITS'(W-1) ? acc - pp : acc + pp;
    sh_n = {sh[W-1], sh[W-1:1]};
    r1 = F == 3'b000 ? A & B :
         F == 3'b001 ? A | B :
         F == 3'b010 ? sum :
         F == 3'b011 ? dif :
         F == 3'b100 ? A ^ B :
         F == 3'b101 ? {{(W-1){1'b0}}, slt} : A;
    o1 = F == 3'b010 ? (A[W-1] == B[W-1] && sum[W-1] != A[W-1]) :
         F == 3'b011 ? (A[W-1] != B[W-1] && dif[W-1] != A[W-1]) : 1'b0;
    res = state == IDLE ? r1 : (is_mul ? acc_n[W-1:0] : sh_n);
    ovf = state == IDLE ? o1 : (is_mul && acc_n != {{W{acc_n[W-1]}}, acc_n[W-1:0]});
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      Saida <= '0;
      FLAG_O <= 1'b0;
      FLAG_Z <= 1'b0;
      FLAG_N <= 1'b0;
      done <= 1'b0;
      is_mul <= 1'b0;
      acc <= '0;
      mc <= '0;
      mp <= '0;
      sh <= '0;
      cnt <= '0;
    end else begin
      done <= complete;
      if (complete) begin
        Saida <= res;
        FLAG_O <= ovf;
        FLAG_Z <= res == '0;
        FLAG_N <= res[W-1];
      end
      if (accept) begin
        is_mul <= !F[0];
        acc <= '0;
        mc <= {{W{A[W-1]}}, A};
        mp <= B;
        sh <= A;
        cnt <= F[0] ? k : '0;
      end else if (state == EXEC) begin
        acc <= acc_n;
        mc <= mc << 1;
        mp <= mp >> 1;
        sh <= sh_n;
        cnt <= is_mul ? cnt + 1'b1 : cnt - 1'b1;
      end
    end
endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Parametrised, registered, multi-cycle successor to the combinational 4-op ULA.
- Adds XOR, signed set-less-than, signed multiply and arithmetic shift right.
- Adds zero and negative flags and a start/busy/done handshake.
- Sits between the register file and the datapath result bus. Single-cycle ops complete in one clock. MUL and SRA iterate one step per clock.

Parameters:
- NUM_BITS, 8, operand/result width in bits (>=4, power of two).
- SH_BITS, $clog2(NUM_BITS), width of the shift-amount field taken from B.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled on a rising edge only when busy=0.
- F  input  3  operation selector.
- A  input  NUM_BITS  signed operand A.
- B  input  NUM_BITS  signed operand B; B[SH_BITS-1:0] is the shift amount for SRA.
- Saida  output  NUM_BITS  signed result, registered, held until the next completion.
- FLAG_O  output  1  signed overflow of last completed op.
- FLAG_Z  output  1  last result == 0.
- FLAG_N  output  1  last result MSB.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle pulse marking completion; Saida and flags are valid from this cycle.

Behaviour:
- Reset (async, any time, including mid-operation): Saida=0, FLAG_O=FLAG_Z=FLAG_N=0, busy=0, done=0, state=IDLE. Partial MUL/SRA work is discarded.
- States: IDLE, EXEC.
- Start rule: start is accepted on edge E0 only if state=IDLE. A, B and F are latched at E0. Input changes after E0 have no effect. start while busy=1 is ignored entirely; no queuing.
- Single-cycle ops, F=000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT:
  - Result, flags and done=1 are registered at E0. State stays IDLE.
  - Back-to-back starts on consecutive edges are allowed.
- SLT: Saida = (A<B signed) ? 1 : 0.
- ADD: FLAG_O = operand signs equal and result sign differs.
- SUB: FLAG_O = operand signs differ and result sign differs from A. Both polarities of overflow are flagged.
- FLAG_O=0 for AND, OR, XOR, SLT, SRA.
- MUL (F=110):
  - Signed, iterative shift-add, one partial product per cycle.
  - At E0: state->EXEC, busy=1.
  - Exactly NUM_BITS edges later (E_N): Saida = low NUM_BITS bits of the full signed 2*NUM_BITS product, flags updated, done=1, busy=0, state->IDLE.
  - FLAG_O=1 iff the full product is not equal to the sign-extension of Saida.
- SRA (F=111):
  - k = B[SH_BITS-1:0].
  - k=0: behaves as a single-cycle op; result=A at E0.
  - k>=1: state->EXEC, busy=1 at E0. One-bit arithmetic shift per edge. Result, flags and done at E_k; busy=0, state->IDLE.
- FLAG_Z and FLAG_N are computed from the final Saida for every op.
- Outside a completion edge, done=0. Saida and flags are never modified except at a completion edge or reset.
- busy=1 only in EXEC. busy and done are never both 1.

Test Plan (NUM_BITS=8):
- ADD A=100, B=50, start at E0 -> at E0: Saida=0x96 (-106), FLAG_O=1, FLAG_N=1, FLAG_Z=0, done=1 for exactly one cycle.
- SUB A=-128, B=1 -> Saida=0x7F, FLAG_O=1. Then SUB 5-5 on the next edge -> Saida=0, FLAG_Z=1, FLAG_O=0. Two done pulses on consecutive cycles.
- MUL A=-3, B=7 -> busy=1 for 8 cycles, done at E8, Saida=0xEB (-21), FLAG_O=0, FLAG_N=1.
- MUL A=16, B=16 -> done at E8, Saida=0x00, FLAG_O=1, FLAG_Z=1.
- SRA A=0xC0, B=3 -> done at E3, Saida=0xF8 (-8), FLAG_N=1.
- SRA with B=0 -> done at E0, Saida=A.
- Start MUL 6*5, then at E2 assert start with F=000, A=0, B=0 and change A -> ignored. Done at E8 with Saida=30; no extra done pulse.
- Assert reset asynchronously at E4 of a MUL -> immediately all outputs 0, busy=0. After release, ADD 1+1 -> Saida=2 at its start edge.
